fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with branch redirect
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned-target trap to ERR state)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCsrc,
  input  logic [31:0] ImmOp,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] next_pc;

  // Branch target or sequential successor of the held instruction, wrapping mod 2^32
  always_comb begin
    target = PCsrc ? (instr_pc + ImmOp) : (instr_pc + 32'd4);
`ifdef FETCH_MISALIGN_CHK_EN
    next_pc = target;
`else
    next_pc = target & ~32'h3;
`endif
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Fetch sequencer: all outputs are registered and updated alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (next_pc[1:0] != 2'b00) begin
              err_q <= 1'b1;
              state <= ERR;
            end else begin
              pc        <= next_pc;
              imem_addr <= next_pc;
              imem_req  <= 1'b1;
              state     <= REQ;
            end
`else
            pc        <= next_pc;
            imem_addr <= next_pc;
            imem_req  <= 1'b1;
            state     <= REQ;
`endif
          end
        end
        ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction model
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_err;

  int          checks;
  int          errors;
  logic [31:0] mpc;
  bit          erred;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete fetch transaction as seen from the pins; the model pc is advanced
  // from the architectural rule (target or pc+4, word-aligned) at the end.
  task automatic fetch_one(input int delay, input int stalls, input logic psrc,
                           input logic [31:0] imm, output bit err_hit);
    logic [31:0] data;
    logic [31:0] np;
    err_hit = 1'b0;
    check("req_on", imem_req, 1);
    check("req_addr", imem_addr, mpc);
    check("valid_in_req", instr_valid, 0);
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      PCsrc      = 1'($urandom);
      @(negedge clk);
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, mpc);
    end
    data       = $urandom;
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_after_ack", instr_valid, 1);
    check("instr", instr, data);
    check("instr_pc", instr_pc, mpc);
    check("req_off_hold", imem_req, 0);
    for (int i = 0; i < stalls; i++) begin
      stall    = 1'b1;
      PCsrc    = ~PCsrc;
      ImmOp    = $urandom;
      imem_ack = 1'($urandom);
      @(negedge clk);
      check("stall_instr", instr, data);
      check("stall_pc", instr_pc, mpc);
      check("stall_valid", instr_valid, 1);
      check("stall_req", imem_req, 0);
    end
    stall    = 1'b0;
    PCsrc    = psrc;
    ImmOp    = imm;
    imem_ack = 1'b0;
    np = psrc ? (mpc + imm) : (mpc + 32'd4);
    @(negedge clk);
    stall = 1'($urandom);
    PCsrc = 1'($urandom);
    ImmOp = $urandom;
    check("valid_cleared", instr_valid, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    if (np[1:0] != 2'b00) begin
      err_hit = 1'b1;
      check("err_set", fetch_err, 1);
      check("err_req", imem_req, 0);
      return;
    end
`endif
    mpc = np & ~32'h3;
    check("no_err", fetch_err, 0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    PCsrc      = 1'b0;
    ImmOp      = 32'h0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_err, 0);
    rst = 1'b0;
    check("idle_req", imem_req, 0);
    @(negedge clk);
    mpc = 32'h0;

    // sequential fetches 0 -> 4 -> 8, then backward branch from 8 by -8
    fetch_one(0, 0, 1'b0, 32'h0, erred);
    fetch_one(0, 0, 1'b0, 32'h0, erred);
    check("at_8", mpc, 32'h8);
    fetch_one(0, 0, 1'b1, 32'hFFFF_FFF8, erred);
    check("branch_back_addr", imem_addr, 32'h0);

    // five stall cycles with PCsrc toggling, release selects the taken target
    fetch_one(1, 5, 1'b1, 32'h100, erred);
    check("stall_target", imem_addr, 32'h100);

    // reach the top word and wrap sequentially to zero
    fetch_one(0, 0, 1'b1, 32'hFFFF_FFFC - 32'h100, erred);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_one(2, 1, 1'b0, 32'h0, erred);
    check("wrap_addr", imem_addr, 32'h0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] imm;
      imm = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
      imm = imm & ~32'h3;
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), imm, erred);
    end

    // reset while a request waits on a slow memory; the late ack lands in IDLE
    check("pre_rst_req", imem_req, 1);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_req_drop", imem_req, 0);
    check("async_valid_drop", instr_valid, 0);
    @(negedge clk);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 32'h0);
    check("late_ack_ignored", instr_valid, 0);
    mpc = 32'h0;

    // misaligned branch target from 0x4
    fetch_one(0, 0, 1'b0, 32'h0, erred);
    fetch_one(0, 0, 1'b1, 32'h2, erred);
`ifdef FETCH_MISALIGN_CHK_EN
    check("misalign_trapped", 32'(erred), 1);
    repeat (3) begin
      imem_ack = 1'($urandom);
      stall    = 1'($urandom);
      @(negedge clk);
      check("err_sticky", fetch_err, 1);
      check("err_no_req", imem_req, 0);
      check("err_no_valid", instr_valid, 0);
    end
`else
    check("misalign_forced", imem_addr, 32'h4);
    check("misalign_req", imem_req, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
